// File: rtl/param_loader.sv
// param_loader: UART (8N1) byte receiver and 6-byte checksummed frame decoder.
// Valid frames write shadow registers; a commit frame copies all shadows to the
// active outputs on a single edge so the pulse generator sees an atomic update.
module param_loader #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned TIMEOUT_CLKS = 120000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        RS232_Rx,
   output logic [31:0] period,
   output logic [31:0] p1width,
   output logic [31:0] delay,
   output logic [31:0] p2width,
   output logic [6:0]  pre_att,
   output logic [6:0]  post_att,
   output logic [7:0]  cpmg,
   output logic [7:0]  pulse_block,
   output logic [15:0] pulse_block_off,
   output logic        pump,
   output logic        block,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        commit
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CLKS);

   localparam logic [2:0] U_IDLE = 3'd0, U_START = 3'd1, U_DATA = 3'd2,
                          U_STOP = 3'd3, U_WAIT_HIGH = 3'd4;
   localparam logic [1:0] F_CMD = 2'd0, F_DATA = 2'd1, F_CHK = 2'd2;
   localparam logic [7:0] CMD_COMMIT = 8'hA5;

   logic             rx_meta_q, rx_sync_q;
   logic [2:0]       u_state_q, u_state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_vld_q, byte_vld_d;
   logic             ferr_c;

   logic [1:0]       f_state_q, f_state_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       xor_q, xor_d;
   logic [31:0]      data_q, data_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             known_c;
   logic             frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, commit_q, commit_d;

   logic [31:0] sh_period_q, sh_period_d, sh_p1width_q, sh_p1width_d;
   logic [31:0] sh_delay_q, sh_delay_d, sh_p2width_q, sh_p2width_d;
   logic [6:0]  sh_pre_att_q, sh_pre_att_d, sh_post_att_q, sh_post_att_d;
   logic [7:0]  sh_cpmg_q, sh_cpmg_d, sh_pb_q, sh_pb_d;
   logic [15:0] sh_pbo_q, sh_pbo_d;
   logic        sh_pump_q, sh_pump_d, sh_block_q, sh_block_d;

   logic [31:0] act_period_q, act_period_d, act_p1width_q, act_p1width_d;
   logic [31:0] act_delay_q, act_delay_d, act_p2width_q, act_p2width_d;
   logic [6:0]  act_pre_att_q, act_pre_att_d, act_post_att_q, act_post_att_d;
   logic [7:0]  act_cpmg_q, act_cpmg_d, act_pb_q, act_pb_d;
   logic [15:0] act_pbo_q, act_pbo_d;
   logic        act_pump_q, act_pump_d, act_block_q, act_block_d;

   // Two-flop synchronizer for the asynchronous receive line (idles high).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RS232_Rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // UART receiver: mid-bit sampling from the start-bit edge, LSB first.
   always_comb begin
      u_state_d  = u_state_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      byte_vld_d = 1'b0;
      ferr_c     = 1'b0;
      case (u_state_q)
         U_IDLE: begin
            if (!rx_sync_q) begin
               u_state_d = U_START;
               bit_cnt_d = '0;
            end
         end
         U_START: begin
            if (bit_cnt_q == HALF_LAST) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               u_state_d = rx_sync_q ? U_IDLE : U_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         U_DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) u_state_d = U_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         U_STOP: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (rx_sync_q) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shift_q;
                  u_state_d  = U_IDLE;
               end else begin
                  ferr_c    = 1'b1;
                  u_state_d = U_WAIT_HIGH;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         U_WAIT_HIGH: begin
            if (rx_sync_q) u_state_d = U_IDLE;
         end
         default: u_state_d = U_IDLE;
      endcase
   end

   assign known_c = ((cmd_q >= 8'h01) && (cmd_q <= 8'h0A)) || (cmd_q == CMD_COMMIT);

   // Framer, timeout, shadow writes and atomic commit to the active set.
   always_comb begin
      f_state_d   = f_state_q;
      idx_d       = idx_q;
      cmd_d       = cmd_q;
      xor_d       = xor_q;
      data_d      = data_q;
      to_cnt_d    = to_cnt_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      commit_d    = 1'b0;
      sh_period_d = sh_period_q;   sh_p1width_d  = sh_p1width_q;
      sh_delay_d  = sh_delay_q;    sh_p2width_d  = sh_p2width_q;
      sh_pre_att_d = sh_pre_att_q; sh_post_att_d = sh_post_att_q;
      sh_cpmg_d   = sh_cpmg_q;     sh_pb_d       = sh_pb_q;
      sh_pbo_d    = sh_pbo_q;      sh_pump_d     = sh_pump_q;
      sh_block_d  = sh_block_q;
      act_period_d = act_period_q;   act_p1width_d  = act_p1width_q;
      act_delay_d  = act_delay_q;    act_p2width_d  = act_p2width_q;
      act_pre_att_d = act_pre_att_q; act_post_att_d = act_post_att_q;
      act_cpmg_d   = act_cpmg_q;     act_pb_d       = act_pb_q;
      act_pbo_d    = act_pbo_q;      act_pump_d     = act_pump_q;
      act_block_d  = act_block_q;
      if (ferr_c) begin
         frame_err_d = 1'b1;
         f_state_d   = F_CMD;
         to_cnt_d    = '0;
      end else if (byte_vld_q) begin
         // A byte arriving always clears the gap counter, even on the limit cycle.
         to_cnt_d = '0;
         case (f_state_q)
            F_CMD: begin
               cmd_d     = byte_q;
               xor_d     = byte_q;
               idx_d     = '0;
               f_state_d = F_DATA;
            end
            F_DATA: begin
               data_d = {data_q[23:0], byte_q};
               xor_d  = xor_q ^ byte_q;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) f_state_d = F_CHK;
            end
            F_CHK: begin
               f_state_d = F_CMD;
               if ((byte_q == xor_q) && known_c) begin
                  frame_ok_d = 1'b1;
                  case (cmd_q)
                     8'h01: sh_period_d   = data_q;
                     8'h02: sh_p1width_d  = data_q;
                     8'h03: sh_delay_d    = data_q;
                     8'h04: sh_p2width_d  = data_q;
                     8'h05: sh_pre_att_d  = data_q[6:0];
                     8'h06: sh_post_att_d = data_q[6:0];
                     8'h07: sh_cpmg_d     = data_q[7:0];
                     8'h08: sh_pb_d       = data_q[7:0];
                     8'h09: sh_pbo_d      = data_q[15:0];
                     8'h0A: begin
                        sh_pump_d  = data_q[0];
                        sh_block_d = data_q[1];
                     end
                     CMD_COMMIT: begin
                        commit_d       = 1'b1;
                        act_period_d   = sh_period_q;   act_p1width_d  = sh_p1width_q;
                        act_delay_d    = sh_delay_q;    act_p2width_d  = sh_p2width_q;
                        act_pre_att_d  = sh_pre_att_q;  act_post_att_d = sh_post_att_q;
                        act_cpmg_d     = sh_cpmg_q;     act_pb_d       = sh_pb_q;
                        act_pbo_d      = sh_pbo_q;      act_pump_d     = sh_pump_q;
                        act_block_d    = sh_block_q;
                     end
                     default: ;
                  endcase
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: f_state_d = F_CMD;
         endcase
      end else if (f_state_q != F_CMD) begin
         if (to_cnt_q == TO_LIMIT) begin
            frame_err_d = 1'b1;
            f_state_d   = F_CMD;
            to_cnt_d    = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
   end

   // State, shadow and active registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         u_state_q <= U_IDLE;  bit_cnt_q <= '0;  bit_idx_q <= '0;
         shift_q <= '0;  byte_q <= '0;  byte_vld_q <= 1'b0;
         f_state_q <= F_CMD;  idx_q <= '0;  cmd_q <= '0;  xor_q <= '0;
         data_q <= '0;  to_cnt_q <= '0;
         frame_ok_q <= 1'b0;  frame_err_q <= 1'b0;  commit_q <= 1'b0;
         sh_period_q <= '0;  sh_p1width_q <= '0;  sh_delay_q <= '0;  sh_p2width_q <= '0;
         sh_pre_att_q <= '0;  sh_post_att_q <= '0;  sh_cpmg_q <= '0;  sh_pb_q <= '0;
         sh_pbo_q <= '0;  sh_pump_q <= 1'b0;  sh_block_q <= 1'b0;
         act_period_q <= '0;  act_p1width_q <= '0;  act_delay_q <= '0;  act_p2width_q <= '0;
         act_pre_att_q <= '0;  act_post_att_q <= '0;  act_cpmg_q <= '0;  act_pb_q <= '0;
         act_pbo_q <= '0;  act_pump_q <= 1'b0;  act_block_q <= 1'b0;
      end else begin
         u_state_q <= u_state_d;  bit_cnt_q <= bit_cnt_d;  bit_idx_q <= bit_idx_d;
         shift_q <= shift_d;  byte_q <= byte_d;  byte_vld_q <= byte_vld_d;
         f_state_q <= f_state_d;  idx_q <= idx_d;  cmd_q <= cmd_d;  xor_q <= xor_d;
         data_q <= data_d;  to_cnt_q <= to_cnt_d;
         frame_ok_q <= frame_ok_d;  frame_err_q <= frame_err_d;  commit_q <= commit_d;
         sh_period_q <= sh_period_d;  sh_p1width_q <= sh_p1width_d;
         sh_delay_q <= sh_delay_d;  sh_p2width_q <= sh_p2width_d;
         sh_pre_att_q <= sh_pre_att_d;  sh_post_att_q <= sh_post_att_d;
         sh_cpmg_q <= sh_cpmg_d;  sh_pb_q <= sh_pb_d;  sh_pbo_q <= sh_pbo_d;
         sh_pump_q <= sh_pump_d;  sh_block_q <= sh_block_d;
         act_period_q <= act_period_d;  act_p1width_q <= act_p1width_d;
         act_delay_q <= act_delay_d;  act_p2width_q <= act_p2width_d;
         act_pre_att_q <= act_pre_att_d;  act_post_att_q <= act_post_att_d;
         act_cpmg_q <= act_cpmg_d;  act_pb_q <= act_pb_d;  act_pbo_q <= act_pbo_d;
         act_pump_q <= act_pump_d;  act_block_q <= act_block_d;
      end
   end

   assign period          = act_period_q;
   assign p1width         = act_p1width_q;
   assign delay           = act_delay_q;
   assign p2width         = act_p2width_q;
   assign pre_att         = act_pre_att_q;
   assign post_att        = act_post_att_q;
   assign cpmg            = act_cpmg_q;
   assign pulse_block     = act_pb_q;
   assign pulse_block_off = act_pbo_q;
   assign pump            = act_pump_q;
   assign block           = act_block_q;
   assign frame_ok        = frame_ok_q;
   assign frame_err       = frame_err_q;
   assign commit          = commit_q;

endmodule
